// File: rtl/instruction_fetch_controller_pkg.sv
// Shared CPU definitions: fetch FSM encoding and the default reset PC.
// The IDLE/FETCH/FAULT constants are also used by hazard and debug logic.
package instruction_fetch_controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] IFC_RESET_PC    = 32'd0;
  localparam logic [31:0] FETCH_COUNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/instruction_fetch_controller_output_stage.sv
// Single-entry output register presenting fetched instructions downstream.
//
// Handshake: valid_o/data_o/pc_o are driven from registers. A transfer happens
// on a rising edge where valid_o and ready_i are both 1. While valid_o=1 and no
// transfer occurs, data_o and pc_o are held stable. accept_o tells the fetch
// logic that a capture this cycle will not overwrite an untransferred entry.
module fetch_output_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture_i,
  input  logic        flush_i,
  input  logic        ready_i,
  input  logic [31:0] data_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic [31:0] pc_o,
  output logic        transfer_o,
  output logic        accept_o
);

  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [31:0] pc_q, pc_d;

  assign transfer_o = valid_q & ready_i;
  assign accept_o   = ~valid_q | transfer_o;
  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign pc_o       = pc_q;

  // Next entry: flush drops the entry, capture loads a new one, transfer empties.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (transfer_o) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      pc_q    <= 32'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: walks the PC through an external combinational
// instruction memory, presents words through a one-entry output register,
// honours redirects and traps when the PC leaves the memory range.
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH = 50,
  parameter logic [31:0] RESET_PC     = IFC_RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [31:0]  im_addr,
  input  logic [31:0]  im_data,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  instr_data,
  output logic [31:0]  instr_pc,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         fault,
  output logic [31:0]  fetch_count,
  output fetch_state_e dbg_state
);

  localparam logic [31:0] DEPTH = 32'(MEMORY_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  pc_plus1;
  logic         capture, flush, transfer, accept;

  assign pc_plus1    = pc_q + 32'd1;
  assign im_addr     = pc_q;
  assign fault       = (state_q == FAULT);
  assign fetch_count = count_q;
  assign dbg_state   = state_q;

  fetch_output_stage u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture_i  (capture),
    .flush_i    (flush),
    .ready_i    (instr_ready),
    .data_i     (im_data),
    .pc_i       (pc_q),
    .valid_o    (instr_valid),
    .data_o     (instr_data),
    .pc_o       (instr_pc),
    .transfer_o (transfer),
    .accept_o   (accept)
  );

  // Next state and PC; a redirect overrides start and capture in every state.
  // The run-off check uses PC+1 so the trap is taken right after the last
  // in-range word is captured, never wrapping back into the memory.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_pc;
      state_d = (redirect_pc >= DEPTH) ? FAULT : FETCH;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = (pc_q >= DEPTH) ? FAULT : FETCH;
        end
        FETCH: begin
          if (pc_q >= DEPTH) begin
            state_d = FAULT;
          end else if (accept) begin
            capture = 1'b1;
            pc_d    = pc_plus1;
            if (pc_plus1 >= DEPTH) state_d = FAULT;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating count of completed downstream transfers.
  always_comb begin
    count_d = count_q;
    if (transfer && (count_q != FETCH_COUNT_MAX)) count_d = count_q + 32'd1;
  end

  // State, PC and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

endmodule
